shift_reg_univ: RTL and testbench



---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_bit_counter.sv | 55 +++++
 rtl/shift_reg_univ.sv | 83 ++++++++
 tb/tb_shift_reg_univ.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : shared mode encoding for shift-register and serial-link blocks
// Revision  : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    SM_HOLD = 2'b00,
    SM_SHR  = 2'b01,
    SM_SHL  = 2'b10,
    SM_LOAD = 2'b11
  } shift_mode_e;

endpackage

`default_nettype wire

// File: rtl/shift_bit_counter.sv
// ============================================================================
// shift_bit_counter : modulo-WIDTH counter with clear, increment, wrap strobe
// Revision          : 1.0
// ============================================================================
`default_nettype none

module shift_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  // Clear beats increment so a load never reports a boundary.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (cnt_q == C_LAST) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

`default_nettype wire

// File: rtl/shift_reg_univ.sv
// ============================================================================
// shift_reg_univ : universal hold/shift-right/shift-left/load register
// Revision       : 1.0
// ============================================================================
`default_nettype none

module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] po,
  output logic             so_r,
  output logic             so_l,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_done
);

  logic [WIDTH-1:0] po_q, po_d;
  logic             cnt_clr;
  logic             cnt_inc;
  shift_mode_e      mode_e;

  assign mode_e = shift_mode_e'(mode);

  always_comb begin
    po_d    = po_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (en) begin
      case (mode_e)
        SM_SHR: begin
          po_d    = {sr_in, po_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        SM_SHL: begin
          po_d    = {po_q[WIDTH-2:0], sl_in};
          cnt_inc = 1'b1;
        end
        SM_LOAD: begin
          po_d    = pi;
          cnt_clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      po_q <= '0;
    end else begin
      po_q <= po_d;
    end
  end

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (bit_cnt),
    .wrap_o (word_done)
  );

  assign po   = po_q;
  assign so_r = po_q[0];
  assign so_l = po_q[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
// ============================================================================
// tb_shift_reg_univ : directed checks of shift_reg_univ at WIDTH=4 and WIDTH=8
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_shift_reg_univ;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       sr_in;
  logic       sl_in;
  logic [3:0] pi;
  logic [3:0] po;
  logic       so_r;
  logic       so_l;
  logic [1:0] bit_cnt;
  logic       word_done;

  logic       en8;
  logic [1:0] mode8;
  logic       sr_in8;
  logic [7:0] po8;
  logic       so_r8;
  logic       so_l8;
  logic [2:0] bit_cnt8;
  logic       word_done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sr_in(sr_in), .sl_in(sl_in),
    .pi(pi), .po(po), .so_r(so_r), .so_l(so_l), .bit_cnt(bit_cnt),
    .word_done(word_done)
  );

  shift_reg_univ #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .sr_in(sr_in8), .sl_in(1'b0),
    .pi(8'h00), .po(po8), .so_r(so_r8), .so_l(so_l8), .bit_cnt(bit_cnt8),
    .word_done(word_done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic e, input logic [1:0] m, input logic sr,
                      input logic sl, input logic [3:0] p);
    en = e; mode = m; sr_in = sr; sl_in = sl; pi = p;
    @(posedge clk); #1;
  endtask

  task automatic expect4(input string tag, input logic [3:0] e_po,
                         input logic [1:0] e_cnt, input logic e_wd);
    chk({tag, ".po"},  32'(po),        32'(e_po));
    chk({tag, ".cnt"}, 32'(bit_cnt),   32'(e_cnt));
    chk({tag, ".wd"},  32'(word_done), 32'(e_wd));
  endtask

  initial begin
    logic [3:0] sipo_po [4];
    logic [3:0] piso_po [4];
    logic       piso_sol[4];
    logic [7:0] pat;
    int         pulses;

    sipo_po  = '{4'b1000, 4'b0100, 4'b0010, 4'b1001};
    piso_po  = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
    piso_sol = '{1'b0, 1'b1, 1'b1, 1'b0};
    pat      = 8'hA5;

    en8 = 1'b0; mode8 = SM_HOLD; sr_in8 = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'($urandom_range(3)), 1'($urandom), 1'($urandom), 4'($urandom));
      expect4("reset", 4'b0000, 2'd0, 1'b0);
    end
    chk("reset8.po", 32'(po8), 32'h0);
    rst = 1'b0;

    // SIPO compatibility
    for (int i = 0; i < 4; i++) begin
      step(1'b1, SM_SHR, sipo_po[i][3], 1'b0, 4'h0);
      expect4("sipo", sipo_po[i], 2'((i + 1) % 4), (i == 3));
    end
    chk("sipo.so_r", 32'(so_r), 32'h1);
    step(1'b1, SM_HOLD, 1'b0, 1'b0, 4'h0);
    expect4("sipo_hold", 4'b1001, 2'd0, 1'b0);

    // PISO
    step(1'b1, SM_LOAD, 1'b0, 1'b0, 4'b1011);
    expect4("piso_load", 4'b1011, 2'd0, 1'b0);
    chk("piso.so_l0", 32'(so_l), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, SM_SHL, 1'b0, 1'b0, 4'h0);
      expect4("piso", piso_po[i], 2'((i + 1) % 4), (i == 3));
      chk("piso.so_l", 32'(so_l), 32'(piso_sol[i]));
    end

    // Pause: en holes and a mode hold must not lose the count
    pulses = 0;
    step(1'b1, SM_SHR, 1'b1, 1'b0, 4'h0);
    expect4("pause_s1", 4'b1000, 2'd1, 1'b0);
    step(1'b1, SM_SHR, 1'b1, 1'b0, 4'h0);
    expect4("pause_s2", 4'b1100, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, SM_SHL, 1'b1, 1'b1, 4'hF);
      expect4("pause_en0", 4'b1100, 2'd2, 1'b0);
    end
    step(1'b1, SM_HOLD, 1'b1, 1'b1, 4'hF);
    expect4("pause_hold", 4'b1100, 2'd2, 1'b0);
    step(1'b1, SM_SHR, 1'b0, 1'b0, 4'h0);
    expect4("pause_s3", 4'b0110, 2'd3, 1'b0);
    step(1'b1, SM_SHR, 1'b0, 1'b0, 4'h0);
    expect4("pause_s4", 4'b0011, 2'd0, 1'b1);
    pulses += int'(word_done);
    step(1'b1, SM_HOLD, 1'b0, 1'b0, 4'h0);
    pulses += int'(word_done);
    chk("pause.pulses", 32'(pulses), 32'd1);

    // Load mid-word: load wins over a pending boundary
    step(1'b1, SM_SHR, 1'b1, 1'b0, 4'h0);
    expect4("lmid_s1", 4'b1001, 2'd1, 1'b0);
    step(1'b1, SM_SHR, 1'b1, 1'b0, 4'h0);
    expect4("lmid_s2", 4'b1100, 2'd2, 1'b0);
    step(1'b1, SM_SHR, 1'b1, 1'b0, 4'h0);
    expect4("lmid_s3", 4'b1110, 2'd3, 1'b0);
    step(1'b1, SM_LOAD, 1'b1, 1'b0, 4'b0110);
    expect4("lmid_load", 4'b0110, 2'd0, 1'b0);
    step(1'b1, SM_SHL, 1'b0, 1'b1, 4'h0);
    expect4("lmid_a", 4'b1101, 2'd1, 1'b0);
    step(1'b1, SM_SHL, 1'b0, 1'b1, 4'h0);
    expect4("lmid_b", 4'b1011, 2'd2, 1'b0);
    step(1'b1, SM_SHL, 1'b0, 1'b1, 4'h0);
    expect4("lmid_c", 4'b0111, 2'd3, 1'b0);
    step(1'b1, SM_SHL, 1'b0, 1'b1, 4'h0);
    expect4("lmid_d", 4'b1111, 2'd0, 1'b1);

    // Reset asserted mid-word overrides an enabled shift
    step(1'b1, SM_SHR, 1'b0, 1'b0, 4'h0);
    step(1'b1, SM_SHR, 1'b0, 1'b0, 4'h0);
    expect4("rmid_pre", 4'b0011, 2'd2, 1'b0);
    rst = 1'b1;
    step(1'b1, SM_SHR, 1'b1, 1'b1, 4'hF);
    expect4("rmid", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;

    // WIDTH=8: continuous right shifts, LSB of the pattern first
    en = 1'b0; mode = SM_HOLD;
    for (int k = 0; k < 16; k++) begin
      en8 = 1'b1; mode8 = SM_SHR; sr_in8 = pat[k % 8];
      @(posedge clk); #1;
      chk("w8.wd", 32'(word_done8), 32'((k == 7) || (k == 15)));
      chk("w8.cnt", 32'(bit_cnt8), 32'((k + 1) % 8));
      if (k == 7 || k == 15) chk("w8.po", 32'(po8), 32'hA5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
